midi_voice_alloc: RTL and testbench
===================================

# midi_voice_alloc

Voice allocator sitting directly upstream of the synth core. It accepts decoded MIDI channel-voice messages, maintains a table mapping (channel, note) to voice slots, and emits the single-cycle `note_pressed` / `note_released` / `note_keypress` pulses that the synth core consumes. Each pulse carries `note`, `velocity`, `channel` and the slot `addr` into the synth's control RAM. When every slot is busy, the oldest voice is stolen.

## Interface
- `NUM_VOICES`, 128: voice slots; output `addr` range is 0..NUM_VOICES-1.
- `STAMP_W`, 16: width of the allocation timestamp.
- `clk32`  in  1  system clock, 32 MHz.
- `rst`  in  1  reset, synchronous, active-low.
- `msg_valid`  in  1  message present.
- `msg_ready`  out  1  block can accept a message; transfer happens when valid && ready.
- `msg_type`  in  2  message type: 0 = NOTE_ON, 1 = NOTE_OFF, 2 = POLY_KEYPRESS, 3 = ALL_OFF.
- `msg_channel`  in  4  MIDI channel.
- `msg_note`  in  7  note number.
- `msg_velocity`  in  7  velocity or pressure.
- `note_pressed`, `note_released`, `note_keypress`  out  1 each  one-cycle event pulses; mutually exclusive.
- `note`  out  7, `velocity`  out  7, `channel`  out  4  event payload.
- `addr`  out  8  voice slot for the event.

## Operation
- **Table.** Each slot holds {active, channel[3:0], note[6:0], stamp[STAMP_W-1:0]}. There is a global `stamp_cnt`. For every entry, age = `stamp_cnt` - stamp, computed modulo 2^STAMP_W.
- **FSM states:** CLEAR, IDLE, SCAN, EMIT, GAP, ALLSCAN.
  - **CLEAR.** Entered on reset. Walks slots 0..NUM_VOICES-1 writing active=0 and stamp=0, then goes to IDLE.
  - **IDLE.** `msg_ready`=1. On accept, latches the message and goes to SCAN, or to ALLSCAN if `msg_type` = ALL_OFF.
  - **SCAN.** Reads one slot per cycle. It tracks three candidates: the first match (active with equal channel and note), the first free slot (lowest index), and the oldest active slot (maximum age, ties go to the lowest index). Goes to EMIT after the last slot is read.
  - **EMIT decision by message type:**
    - NOTE_ON with velocity 0 is treated as NOTE_OFF.
    - NOTE_ON: choose the match, else the free slot, else the oldest slot (steal). Write active=1, channel, note, stamp=`stamp_cnt`. Increment `stamp_cnt`. Pulse `note_pressed`.
    - NOTE_OFF: on a match, write active=0 (stamp kept) and pulse `note_released`. With no match, no pulse and no write.
    - POLY_KEYPRESS: on a match, pulse `note_keypress` with `velocity` = pressure, and leave the table untouched. With no match, no pulse.
  - **GAP.** Two idle cycles after any pulse, then IDLE. The synth core needs this spacing for its control-RAM read-modify-write.
  - **ALLSCAN.** Walks all slots. For each active slot: emit `note_released` with that slot's note, channel and addr, `velocity`=0, clear active, then 2 gap cycles. Inactive slots cost 1 cycle each. After the last slot, returns to IDLE.
- **Payload outputs.** `note`, `velocity`, `channel` and `addr` update on the pulse cycle and hold until the next pulse.

## Timing
- **Reset values.** All outputs are 0, including `msg_ready`. `stamp_cnt` is 0. CLEAR lasts NUM_VOICES cycles after `rst` returns high; `msg_ready` rises on the following cycle.
- **Latency.** Accept at cycle T; the pulse is at T+NUM_VOICES+2, because table reads are registered with 1-cycle latency. `msg_ready` is low from T+1 through the end of GAP and high again at T+NUM_VOICES+5.
- **Dropped message.** A message producing no pulse skips GAP, so `msg_ready` returns at T+NUM_VOICES+3.
- **Pulses.** Every pulse is exactly 1 cycle. Consecutive pulses are at least 3 cycles apart.
- **Stamp wrap.** `stamp_cnt` wraps at 2^STAMP_W. Because age uses modulo subtraction, steal order stays correct across the wrap, provided no voice survives 2^STAMP_W note-ons.
- **Reset mid-operation.** Reset in any state aborts the operation with no further pulses, re-enters CLEAR, and invalidates the whole table.

## Structure
- Shared package `synth_pkg`:
  - message-type encodings;
  - the state enum;
  - the table entry struct and its width (12+STAMP_W bits);
  - `MAX_SND_MEM` = 128, shared with the synth core.
- Sub-module `voice_table`: single-port NUM_VOICES × (12+STAMP_W) RAM with registered read and a write port, inferred as distributed or block RAM.

## Test plan
- **Reset and first note.** Reset, then NOTE_ON ch 0, note 60, vel 100 → `msg_ready` low for 128 cycles after reset. The message gets `note_pressed` with addr 0, note 60, vel 100 exactly 130 cycles after accept.
- **Release.** NOTE_ON ch2/n64 → addr 1, then NOTE_OFF ch2/n64 → `note_released` addr 1, velocity = message velocity. A second NOTE_OFF ch2/n64 → no pulse, and `msg_ready` returns 131 cycles after accept.
- **Retrigger and velocity 0.** NOTE_ON ch0/n60 issued twice → both pulses at addr 0. A following NOTE_ON ch0/n60 with vel 0 → `note_released` addr 0.
- **Voice stealing.** Fill 128 slots (notes 0..127, ch 1), then NOTE_ON ch3/n50 → `note_pressed` addr 0, the oldest slot. A next NOTE_ON ch3/n51 → addr 1.
- **Keypress.** POLY_KEYPRESS ch1/n5, pressure 77 while note 5 is active in slot 5 → `note_keypress` addr 5, velocity 77, table unchanged. Then ALL_OFF with slots 3 and 9 active → `note_released` at addr 3 and addr 9 only, ≥3 cycles apart.
- **Mid-scan reset and stamp wrap.** Assert `rst` mid-SCAN → no pulse, CLEAR repeats, and a subsequent NOTE_ON gets addr 0. Preload `stamp_cnt` to 0xFFFE, allocate three notes across the wrap, fill the table, then one more NOTE_ON → the first-allocated slot is stolen.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions between the voice allocator and the synth core:
// message encodings, allocator FSM states and the voice-table entry layout.
package synth_pkg;

    // Depth of the synth core's control RAM; one voice slot per entry.
    localparam int MAX_SND_MEM = 128;

    // Allocation timestamp width and the resulting table entry width.
    localparam int STAMP_W = 16;
    localparam int ENTRY_W = 12 + STAMP_W;

    typedef enum logic [1:0] {
        MSG_NOTE_ON       = 2'd0,
        MSG_NOTE_OFF      = 2'd1,
        MSG_POLY_KEYPRESS = 2'd2,
        MSG_ALL_OFF       = 2'd3
    } msg_type_e;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_GAP,
        ST_ALLSCAN
    } state_e;

    typedef struct packed {
        logic               active;
        logic [3:0]         channel;
        logic [6:0]         note;
        logic [STAMP_W-1:0] stamp;
    } entry_t;

    // Age is a modulo difference so ordering survives the stamp counter wrap.
    function automatic logic [STAMP_W-1:0] entry_age(input logic [STAMP_W-1:0] now,
                                                      input logic [STAMP_W-1:0] stamp);
        return now - stamp;
    endfunction

endpackage

// File: rtl/voice_table.sv
// Single-port voice table: one access per cycle, write plus registered read.
module voice_table
    import synth_pkg::*;
#(
    parameter int DEPTH = MAX_SND_MEM,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk32,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  entry_t        wdata,
    output entry_t        rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    entry_t             rdata_q;

    // Storage write and read-first registered read at the shared address.
    // NOTE: the array has no reset; the allocator's CLEAR walk initialises every slot.
    always_ff @(posedge clk32) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= entry_t'(mem[addr]);
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/midi_voice_alloc.sv
// MIDI voice allocator: maps (channel, note) onto voice slots, steals the
// oldest voice when full and emits spaced single-cycle events to the synth.
module midi_voice_alloc
    import synth_pkg::*;
#(
    parameter int                 NUM_VOICES = MAX_SND_MEM,
    parameter logic [STAMP_W-1:0] STAMP_INIT = '0
) (
    input  logic       clk32,
    input  logic       rst,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [1:0] msg_type,
    input  logic [3:0] msg_channel,
    input  logic [6:0] msg_note,
    input  logic [6:0] msg_velocity,
    output logic       note_pressed,
    output logic       note_released,
    output logic       note_keypress,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic [3:0] channel,
    output logic [7:0] addr
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(NUM_VOICES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;           // clear index / read-issue index
    logic               dvld_q, dvld_d;         // table read data valid this cycle
    logic [IDX_W-1:0]   didx_q, didx_d;         // slot the read data belongs to
    logic               gap_q, gap_d;
    logic               all_mode_q, all_mode_d;

    msg_type_e          m_type_q, m_type_d;
    logic [3:0]         m_ch_q, m_ch_d;
    logic [6:0]         m_note_q, m_note_d;
    logic [6:0]         m_vel_q, m_vel_d;

    logic               match_vld_q, match_vld_d;
    logic [IDX_W-1:0]   match_idx_q, match_idx_d;
    logic [STAMP_W-1:0] match_stamp_q, match_stamp_d;
    logic               free_vld_q, free_vld_d;
    logic [IDX_W-1:0]   free_idx_q, free_idx_d;
    logic               old_vld_q, old_vld_d;
    logic [IDX_W-1:0]   old_idx_q, old_idx_d;
    logic [STAMP_W-1:0] old_age_q, old_age_d;

    logic [STAMP_W-1:0] stamp_cnt_q, stamp_cnt_d;

    logic               wr_en_q, wr_en_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    entry_t             wr_data_q, wr_data_d;

    logic               pressed_q, pressed_d;
    logic               released_q, released_d;
    logic               keypress_q, keypress_d;
    logic [6:0]         note_q, note_d;
    logic [6:0]         vel_q, vel_d;
    logic [3:0]         ch_q, ch_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic               ready_q, ready_d;

    logic               tbl_we;
    logic [IDX_W-1:0]   tbl_idx;
    entry_t             tbl_wdata;
    entry_t             rd;
    logic [STAMP_W-1:0] rd_age;
    logic               rd_hit;
    logic [IDX_W-1:0]   sel_idx;

    voice_table #(
        .DEPTH (NUM_VOICES),
        .AW    (IDX_W)
    ) u_table (
        .clk32 (clk32),
        .we    (tbl_we),
        .addr  (tbl_idx),
        .wdata (tbl_wdata),
        .rdata (rd)
    );

    // Next-state, candidate tracking, event decision and table port steering.
    always_comb begin
        // NOTE: every _d starts from its _q (pulses from 0) so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        dvld_d        = 1'b0;
        didx_d        = didx_q;
        gap_d         = gap_q;
        all_mode_d    = all_mode_q;
        m_type_d      = m_type_q;
        m_ch_d        = m_ch_q;
        m_note_d      = m_note_q;
        m_vel_d       = m_vel_q;
        match_vld_d   = match_vld_q;
        match_idx_d   = match_idx_q;
        match_stamp_d = match_stamp_q;
        free_vld_d    = free_vld_q;
        free_idx_d    = free_idx_q;
        old_vld_d     = old_vld_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        stamp_cnt_d   = stamp_cnt_q;
        wr_en_d       = 1'b0;
        wr_idx_d      = wr_idx_q;
        wr_data_d     = wr_data_q;
        pressed_d     = 1'b0;
        released_d    = 1'b0;
        keypress_d    = 1'b0;
        note_d        = note_q;
        vel_d         = vel_q;
        ch_d          = ch_q;
        addr_d        = addr_q;
        tbl_we        = 1'b0;
        tbl_idx       = cnt_q[IDX_W-1:0];
        tbl_wdata     = '0;
        sel_idx       = '0;

        rd_age = entry_age(stamp_cnt_q, rd.stamp);
        rd_hit = rd.active && (rd.channel == m_ch_q) && (rd.note == m_note_q);

        // Fold the slot just read into the three allocation candidates.
        if (state_q == ST_SCAN && dvld_q) begin
            if (rd_hit && !match_vld_q) begin
                match_vld_d   = 1'b1;
                match_idx_d   = didx_q;
                match_stamp_d = rd.stamp;
            end
            if (!rd.active && !free_vld_q) begin
                free_vld_d = 1'b1;
                free_idx_d = didx_q;
            end
            // Strict compare keeps the lowest index on equal ages.
            if (rd.active && (!old_vld_q || rd_age > old_age_q)) begin
                old_vld_d = 1'b1;
                old_idx_d = didx_q;
                old_age_d = rd_age;
            end
        end

        unique case (state_q)
            ST_CLEAR: begin
                tbl_we = 1'b1;
                if (cnt_q[IDX_W-1:0] == IDX_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_IDLE: begin
                if (msg_valid) begin
                    // Velocity-0 NOTE_ON is folded into NOTE_OFF right here.
                    if (msg_type_e'(msg_type) == MSG_NOTE_ON && msg_velocity == 7'd0) begin
                        m_type_d = MSG_NOTE_OFF;
                    end else begin
                        m_type_d = msg_type_e'(msg_type);
                    end
                    m_ch_d      = msg_channel;
                    m_note_d    = msg_note;
                    m_vel_d     = msg_velocity;
                    match_vld_d = 1'b0;
                    free_vld_d  = 1'b0;
                    old_vld_d   = 1'b0;
                    old_age_d   = '0;
                    cnt_d       = '0;
                    all_mode_d  = (msg_type_e'(msg_type) == MSG_ALL_OFF);
                    state_d     = (msg_type_e'(msg_type) == MSG_ALL_OFF) ? ST_ALLSCAN : ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (cnt_q != CNT_END) begin
                    dvld_d = 1'b1;
                    didx_d = cnt_q[IDX_W-1:0];
                    cnt_d  = cnt_q + 1'b1;
                end
                if (dvld_q && didx_q == IDX_LAST) begin
                    state_d = ST_EMIT;
                    unique case (m_type_q)
                        MSG_NOTE_ON: begin
                            if (match_vld_d)     sel_idx = match_idx_d;
                            else if (free_vld_d) sel_idx = free_idx_d;
                            else                 sel_idx = old_idx_d;
                            pressed_d         = 1'b1;
                            note_d            = m_note_q;
                            vel_d             = m_vel_q;
                            ch_d              = m_ch_q;
                            addr_d            = sel_idx;
                            wr_en_d           = 1'b1;
                            wr_idx_d          = sel_idx;
                            wr_data_d.active  = 1'b1;
                            wr_data_d.channel = m_ch_q;
                            wr_data_d.note    = m_note_q;
                            wr_data_d.stamp   = stamp_cnt_q;
                            stamp_cnt_d       = stamp_cnt_q + 1'b1;
                        end
                        MSG_NOTE_OFF: begin
                            if (match_vld_d) begin
                                released_d        = 1'b1;
                                note_d            = m_note_q;
                                vel_d             = m_vel_q;
                                ch_d              = m_ch_q;
                                addr_d            = match_idx_d;
                                wr_en_d           = 1'b1;
                                wr_idx_d          = match_idx_d;
                                wr_data_d.active  = 1'b0;
                                wr_data_d.channel = m_ch_q;
                                wr_data_d.note    = m_note_q;
                                wr_data_d.stamp   = match_stamp_d;
                            end
                        end
                        MSG_POLY_KEYPRESS: begin
                            if (match_vld_d) begin
                                keypress_d = 1'b1;
                                note_d     = m_note_q;
                                vel_d      = m_vel_q;
                                ch_d       = m_ch_q;
                                addr_d     = match_idx_d;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_EMIT: begin
                tbl_we    = wr_en_q;
                tbl_idx   = wr_idx_q;
                tbl_wdata = wr_data_q;
                // A dropped message has no pulse and therefore needs no spacing.
                if (pressed_q || released_q || keypress_q) begin
                    gap_d   = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GAP: begin
                if (!gap_q) begin
                    gap_d = 1'b1;
                end else begin
                    state_d = all_mode_q ? ST_ALLSCAN : ST_IDLE;
                end
            end

            ST_ALLSCAN: begin
                if (dvld_q && rd.active) begin
                    // cnt_q already points at the next slot, so it is re-read after the gap.
                    released_d        = 1'b1;
                    note_d            = rd.note;
                    vel_d             = 7'd0;
                    ch_d              = rd.channel;
                    addr_d            = didx_q;
                    wr_en_d           = 1'b1;
                    wr_idx_d          = didx_q;
                    wr_data_d         = rd;
                    wr_data_d.active  = 1'b0;
                    state_d           = ST_EMIT;
                end else if (cnt_q == CNT_END) begin
                    state_d = ST_IDLE;
                end else begin
                    dvld_d = 1'b1;
                    didx_d = cnt_q[IDX_W-1:0];
                    cnt_d  = cnt_q + 1'b1;
                end
            end

            default: state_d = ST_CLEAR;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // State, message, candidate and output registers with synchronous active-low reset.
    // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk32) begin
        if (!rst) begin
            state_q       <= ST_CLEAR;
            cnt_q         <= '0;
            dvld_q        <= 1'b0;
            didx_q        <= '0;
            gap_q         <= 1'b0;
            all_mode_q    <= 1'b0;
            m_type_q      <= MSG_NOTE_ON;
            m_ch_q        <= '0;
            m_note_q      <= '0;
            m_vel_q       <= '0;
            match_vld_q   <= 1'b0;
            match_idx_q   <= '0;
            match_stamp_q <= '0;
            free_vld_q    <= 1'b0;
            free_idx_q    <= '0;
            old_vld_q     <= 1'b0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            stamp_cnt_q   <= STAMP_INIT;
            wr_en_q       <= 1'b0;
            wr_idx_q      <= '0;
            wr_data_q     <= '0;
            pressed_q     <= 1'b0;
            released_q    <= 1'b0;
            keypress_q    <= 1'b0;
            note_q        <= '0;
            vel_q         <= '0;
            ch_q          <= '0;
            addr_q        <= '0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dvld_q        <= dvld_d;
            didx_q        <= didx_d;
            gap_q         <= gap_d;
            all_mode_q    <= all_mode_d;
            m_type_q      <= m_type_d;
            m_ch_q        <= m_ch_d;
            m_note_q      <= m_note_d;
            m_vel_q       <= m_vel_d;
            match_vld_q   <= match_vld_d;
            match_idx_q   <= match_idx_d;
            match_stamp_q <= match_stamp_d;
            free_vld_q    <= free_vld_d;
            free_idx_q    <= free_idx_d;
            old_vld_q     <= old_vld_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            stamp_cnt_q   <= stamp_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_idx_q      <= wr_idx_d;
            wr_data_q     <= wr_data_d;
            pressed_q     <= pressed_d;
            released_q    <= released_d;
            keypress_q    <= keypress_d;
            note_q        <= note_d;
            vel_q         <= vel_d;
            ch_q          <= ch_d;
            addr_q        <= addr_d;
            ready_q       <= ready_d;
        end
    end

    assign msg_ready     = ready_q;
    assign note_pressed  = pressed_q;
    assign note_released = released_q;
    assign note_keypress = keypress_q;
    assign note          = note_q;
    assign velocity      = vel_q;
    assign channel       = ch_q;
    assign addr          = 8'(addr_q);

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed bench for midi_voice_alloc: a behavioural allocation model feeds
// a scoreboard of expected events that a pulse monitor checks against the DUT.
module tb_midi_voice_alloc;

    localparam int          NV         = 128;
    localparam logic [15:0] STAMP_BASE = 16'hFFFE;
    localparam int          WAIT_LIM   = 3000;

    typedef struct packed {
        logic [1:0] kind;   // 1 pressed, 2 released, 3 keypress
        logic [7:0] addr;
        logic [6:0] note;
        logic [6:0] vel;
        logic [3:0] ch;
    } ev_t;

    logic       clk32 = 1'b0;
    logic       rst = 1'b0;
    logic       msg_valid = 1'b0;
    logic       msg_ready;
    logic [1:0] msg_type = 2'd0;
    logic [3:0] msg_channel = 4'd0;
    logic [6:0] msg_note = 7'd0;
    logic [6:0] msg_velocity = 7'd0;
    logic       note_pressed, note_released, note_keypress;
    logic [6:0] note, velocity;
    logic [3:0] channel;
    logic [7:0] addr;

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  last_pulse_cyc = -1;
    ev_t last_ev = '0;
    ev_t exp_q[$];

    logic        mdl_act   [NV];
    logic [3:0]  mdl_ch    [NV];
    logic [6:0]  mdl_note  [NV];
    logic [15:0] mdl_stamp [NV];
    logic [15:0] mdl_cnt;

    midi_voice_alloc #(
        .NUM_VOICES (NV),
        .STAMP_INIT (STAMP_BASE)
    ) dut (
        .clk32         (clk32),
        .rst           (rst),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .msg_type      (msg_type),
        .msg_channel   (msg_channel),
        .msg_note      (msg_note),
        .msg_velocity  (msg_velocity),
        .note_pressed  (note_pressed),
        .note_released (note_released),
        .note_keypress (note_keypress),
        .note          (note),
        .velocity      (velocity),
        .channel       (channel),
        .addr          (addr)
    );

    always #5 clk32 = ~clk32;

    always @(posedge clk32) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every pulse must be alone, spaced, and match the queue head.
    always @(negedge clk32) begin
        if (note_pressed || note_released || note_keypress) begin
            ev_t got;
            got.kind = note_pressed ? 2'd1 : (note_released ? 2'd2 : 2'd3);
            got.addr = addr;
            got.note = note;
            got.vel  = velocity;
            got.ch   = channel;
            check("pulse_onehot", $countones({note_pressed, note_released, note_keypress}), 1);
            if (last_pulse_cyc >= 0) check("pulse_spacing", 32'(cyc - last_pulse_cyc >= 3), 1);
            last_pulse_cyc = cyc;
            last_ev = got;
            check("pulse_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("pulse_event", got, exp_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            mdl_act[i] = 1'b0;
            mdl_ch[i] = '0;
            mdl_note[i] = '0;
            mdl_stamp[i] = '0;
        end
        mdl_cnt = STAMP_BASE;
    endtask

    // Reference allocation behaviour; pushes the expected events of one message.
    task automatic model_msg(input logic [1:0] t, input logic [3:0] ch, input logic [6:0] n,
                             input logic [6:0] v, output int n_ev);
        int hit = -1;
        int fr = -1;
        int old = -1;
        int sel;
        logic [15:0] best = '0;
        logic [15:0] age;
        logic [1:0] et = (t == 2'd0 && v == 7'd0) ? 2'd1 : t;
        n_ev = 0;
        if (et == 2'd3) begin
            for (int i = 0; i < NV; i++) begin
                if (mdl_act[i]) begin
                    exp_q.push_back({2'd2, 8'(i), mdl_note[i], 7'd0, mdl_ch[i]});
                    mdl_act[i] = 1'b0;
                    n_ev++;
                end
            end
            return;
        end
        for (int i = 0; i < NV; i++) begin
            age = mdl_cnt - mdl_stamp[i];
            if (hit < 0 && mdl_act[i] && mdl_ch[i] == ch && mdl_note[i] == n) hit = i;
            if (fr < 0 && !mdl_act[i]) fr = i;
            if (mdl_act[i] && (old < 0 || age > best)) begin
                old = i;
                best = age;
            end
        end
        if (et == 2'd0) begin
            sel = (hit >= 0) ? hit : ((fr >= 0) ? fr : old);
            exp_q.push_back({2'd1, 8'(sel), n, v, ch});
            mdl_act[sel] = 1'b1;
            mdl_ch[sel] = ch;
            mdl_note[sel] = n;
            mdl_stamp[sel] = mdl_cnt;
            mdl_cnt = mdl_cnt + 16'd1;
            n_ev = 1;
        end else if (hit >= 0) begin
            exp_q.push_back({(et == 2'd1) ? 2'd2 : 2'd3, 8'(hit), n, v, ch});
            if (et == 2'd1) mdl_act[hit] = 1'b0;
            n_ev = 1;
        end
    endtask

    task automatic wait_ready(input string tag);
        int waited = 0;
        while (msg_ready !== 1'b1 && waited < WAIT_LIM) begin
            @(negedge clk32);
            waited++;
        end
        check(tag, 32'(waited < WAIT_LIM), 1);
    endtask

    task automatic do_reset();
        int t0;
        @(negedge clk32);
        rst = 1'b0;
        msg_valid = 1'b0;
        repeat (3) @(negedge clk32);
        check("reset_outputs", {msg_ready, note_pressed, note_released, note_keypress,
                                note, velocity, channel, addr}, 0);
        model_clear();
        rst = 1'b1;
        t0 = cyc;
        wait_ready("clear_timeout");
        check("clear_length", cyc - t0, NV);
    endtask

    task automatic send(input logic [1:0] t, input logic [3:0] ch, input logic [6:0] n,
                        input logic [6:0] v);
        int t_acc;
        int n_ev;
        wait_ready("ready_timeout_pre");
        model_msg(t, ch, n, v, n_ev);
        msg_valid = 1'b1;
        msg_type = t;
        msg_channel = ch;
        msg_note = n;
        msg_velocity = v;
        t_acc = cyc;
        @(negedge clk32);
        msg_valid = 1'b0;
        wait_ready("ready_timeout_post");
        if (t != 2'd3) begin
            check("ready_latency", cyc - t_acc, (n_ev > 0) ? NV + 5 : NV + 3);
            if (n_ev > 0) check("pulse_latency", last_pulse_cyc - t_acc, NV + 2);
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int t_acc;

        // Reset and first note.
        do_reset();
        send(2'd0, 4'd0, 7'd60, 7'd100);
        check("first_note", last_ev, {2'd1, 8'd0, 7'd60, 7'd100, 4'd0});

        // Release, then a redundant release that is dropped.
        send(2'd0, 4'd2, 7'd64, 7'd90);
        check("second_addr", last_ev.addr, 1);
        send(2'd1, 4'd2, 7'd64, 7'd33);
        check("release", last_ev, {2'd2, 8'd1, 7'd64, 7'd33, 4'd2});
        send(2'd1, 4'd2, 7'd64, 7'd33);

        // Retrigger and velocity-0 note-on.
        send(2'd0, 4'd0, 7'd60, 7'd20);
        check("retrigger_addr", last_ev.addr, 0);
        send(2'd0, 4'd0, 7'd60, 7'd0);
        check("vel0_release", last_ev, {2'd2, 8'd0, 7'd60, 7'd0, 4'd0});

        // Fill every slot, then steal the two oldest.
        for (int i = 0; i < NV; i++) send(2'd0, 4'd1, 7'(i), 7'd64);
        check("fill_last_addr", last_ev.addr, NV - 1);
        send(2'd0, 4'd3, 7'd50, 7'd70);
        check("steal_first", last_ev.addr, 0);
        send(2'd0, 4'd3, 7'd51, 7'd71);
        check("steal_second", last_ev.addr, 1);

        // Keypress on an active note; a retrigger then still finds it in place.
        send(2'd2, 4'd1, 7'd5, 7'd77);
        check("keypress", last_ev, {2'd3, 8'd5, 7'd5, 7'd77, 4'd1});
        send(2'd2, 4'd9, 7'd5, 7'd77);
        send(2'd0, 4'd1, 7'd5, 7'd40);
        check("keypress_kept", last_ev.addr, 5);

        // Reset in the middle of a scan aborts the message silently.
        wait_ready("ready_timeout_pre");
        msg_valid = 1'b1;
        msg_type = 2'd0;
        msg_channel = 4'd4;
        msg_note = 7'd99;
        msg_velocity = 7'd99;
        t_acc = cyc;
        @(negedge clk32);
        msg_valid = 1'b0;
        repeat (60) @(negedge clk32);
        check("midscan_busy", msg_ready, 0);
        do_reset();
        check("midscan_no_pulse", 32'(last_pulse_cyc < t_acc), 1);

        // Stamp wrap: three allocations straddle 0xFFFF -> 0x0000.
        send(2'd0, 4'd4, 7'd10, 7'd1);
        check("post_reset_addr", last_ev.addr, 0);
        send(2'd0, 4'd4, 7'd11, 7'd2);
        send(2'd0, 4'd4, 7'd12, 7'd3);
        for (int i = 0; i < NV - 3; i++) send(2'd0, 4'd5, 7'(i), 7'd9);
        send(2'd0, 4'd6, 7'd1, 7'd100);
        check("wrap_steal", last_ev.addr, 0);

        // ALL_OFF with only slots 3 and 9 active.
        do_reset();
        for (int i = 0; i < 10; i++) send(2'd0, 4'd7, 7'(20 + i), 7'd50);
        for (int i = 0; i < 10; i++) begin
            if (i != 3 && i != 9) send(2'd1, 4'd7, 7'(20 + i), 7'd10);
        end
        send(2'd3, 4'd0, 7'd0, 7'd0);
        check("alloff_last", last_ev, {2'd2, 8'd9, 7'd29, 7'd0, 4'd7});
        send(2'd1, 4'd7, 7'd23, 7'd10);

        repeat (5) @(negedge clk32);
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
